// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/enable controller.
// Enable and flush vectors are indexed by the constants below.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int MEM_LAT_MAX = 15;

    localparam int EN_PC = 0;
    localparam int EN_F  = 1;
    localparam int EN_D  = 2;
    localparam int EN_E  = 3;
    localparam int EN_M  = 4;
    localparam int EN_N  = 5;

    localparam int FL_D  = 0;
    localparam int FL_E  = 1;
    localparam int FL_W  = 2;
    localparam int FL_N  = 3;

    // The latency counter is at least one bit wide, even when MEM_LAT is 0.
    function automatic int lat_cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// M-stage memory wait sequencer; fixed-latency by default, handshake with MEM_HS_EN.
//   state | meaning
//   IDLE  | no access in flight; a new request may start a wait
//   WAIT  | access in progress, pipeline held
//   DONE  | release cycle, request ignored (fixed-latency mode only)
module mem_wait_fsm
    import pipe_hazard_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req_m,
`ifdef MEM_HS_EN
    input  logic mem_ready,
`endif
    output logic mem_wait
);

    mem_state_e state_q, state_d;

`ifdef MEM_HS_EN

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_wait = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_m && !mem_ready) begin
                    mem_wait = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                mem_wait = mem_req_m & ~mem_ready;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`else

    localparam int LAT_EFF = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam int CW      = lat_cnt_width(LAT_EFF);
    localparam int LAST_I  = (LAT_EFF > 1) ? (LAT_EFF - 1) : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The IDLE request cycle already counts as the first stall cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_wait = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_m && (LAT_EFF > 0)) begin
                    mem_wait = 1'b1;
                    cnt_d    = CW'(1);
                    state_d  = (LAT_EFF > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                mem_wait = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush controller: load-use detection, memory-wait stall, stall counter.
// Build with MEM_HS_EN defined to use the mem_ready handshake instead of fixed latency.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              rs1_used_d,
    input  logic              rs2_used_d,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              regwrite_e,
    input  logic              load_e,
    input  logic              branch_taken_e,
    input  logic              mem_req_m,
`ifdef MEM_HS_EN
    input  logic              mem_ready,
`endif
    output logic              en_pc,
    output logic              en_f,
    output logic              en_d,
    output logic              en_e,
    output logic              en_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic             rs1_hit;
    logic             rs2_hit;
    logic             lwstall;
    logic             mem_wait;
    logic             ready_w;
    logic [EN_N-1:0]  en_vec;
    logic [FL_N-1:0]  fl_vec;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    mem_wait_fsm #(
        .MEM_LAT   (MEM_LAT)
    ) u_mem_wait_fsm (
        .clk       (clk),
        .rst       (rst),
        .mem_req_m (mem_req_m),
`ifdef MEM_HS_EN
        .mem_ready (mem_ready),
`endif
        .mem_wait  (mem_wait)
    );

    // x0 never carries a dependency, so a load into x0 cannot cause a stall.
    assign rs1_hit = rs1_used_d & (rs1_d == rd_e);
    assign rs2_hit = rs2_used_d & (rs2_d == rd_e);
    assign lwstall = load_e & regwrite_e & (rd_e != '0) & (rs1_hit | rs2_hit);
    assign ready_w = ~mem_wait;

    always_comb begin
        en_vec   = '1;
        fl_vec   = '0;
        mem_busy = 1'b0;
        if (rst) begin
            fl_vec = '1;
        end else begin
            en_vec[EN_PC] = ready_w & ~lwstall;
            en_vec[EN_F]  = ready_w & ~lwstall;
            en_vec[EN_D]  = ready_w & ~lwstall;
            en_vec[EN_E]  = ready_w;
            en_vec[EN_M]  = ready_w;
            // A held memory access masks redirects and bubbles; they reapply on release.
            fl_vec[FL_D]  = branch_taken_e & ready_w;
            fl_vec[FL_E]  = (branch_taken_e | lwstall) & ready_w;
            fl_vec[FL_W]  = mem_wait;
            mem_busy      = mem_wait;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!en_vec[EN_PC] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign en_pc     = en_vec[EN_PC];
    assign en_f      = en_vec[EN_F];
    assign en_d      = en_vec[EN_D];
    assign en_e      = en_vec[EN_E];
    assign en_m      = en_vec[EN_M];
    assign flush_d   = fl_vec[FL_D];
    assign flush_e   = fl_vec[FL_E];
    assign flush_w   = fl_vec[FL_W];
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (MEM_LAT 2, 0 with 3-bit counter, 5).
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] rs1_d, rs2_d, rd_e;
    logic rs1_used_d, rs2_used_d, regwrite_e, load_e, branch_taken_e;
    logic mreq0, mreq2, mreq5;
`ifdef MEM_HS_EN
    logic mem_ready;
`endif

    logic en_pc2, en_f2, en_d2, en_e2, en_m2, fd2, fe2, fw2, busy2;
    logic en_pc0, en_f0, en_d0, en_e0, en_m0, fd0, fe0, fw0, busy0;
    logic en_pc5, en_f5, en_d5, en_e5, en_m5, fd5, fe5, fw5, busy5;
    logic [31:0] sc2, sc5;
    logic [2:0]  sc0;

    logic [4:0] en2, en0, en5;
    logic [2:0] fl2, fl0, fl5;
    assign en2 = {en_pc2, en_f2, en_d2, en_e2, en_m2};
    assign en0 = {en_pc0, en_f0, en_d0, en_e0, en_m0};
    assign en5 = {en_pc5, en_f5, en_d5, en_e5, en_m5};
    assign fl2 = {fd2, fe2, fw2};
    assign fl0 = {fd0, fe0, fw0};
    assign fl5 = {fd5, fe5, fw5};

    pipe_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(2), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .load_e(load_e), .branch_taken_e(branch_taken_e),
        .mem_req_m(mreq2),
`ifdef MEM_HS_EN
        .mem_ready(mem_ready),
`endif
        .en_pc(en_pc2), .en_f(en_f2), .en_d(en_d2), .en_e(en_e2), .en_m(en_m2),
        .flush_d(fd2), .flush_e(fe2), .flush_w(fw2), .mem_busy(busy2), .stall_cnt(sc2)
    );

    pipe_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .load_e(load_e), .branch_taken_e(branch_taken_e),
        .mem_req_m(mreq0),
`ifdef MEM_HS_EN
        .mem_ready(mem_ready),
`endif
        .en_pc(en_pc0), .en_f(en_f0), .en_d(en_d0), .en_e(en_e0), .en_m(en_m0),
        .flush_d(fd0), .flush_e(fe0), .flush_w(fw0), .mem_busy(busy0), .stall_cnt(sc0)
    );

    pipe_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(5), .CNT_W(32)) u_dut5 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .load_e(load_e), .branch_taken_e(branch_taken_e),
        .mem_req_m(mreq5),
`ifdef MEM_HS_EN
        .mem_ready(mem_ready),
`endif
        .en_pc(en_pc5), .en_f(en_f5), .en_d(en_d5), .en_e(en_e5), .en_m(en_m5),
        .flush_d(fd5), .flush_e(fe5), .flush_w(fw5), .mem_busy(busy5), .stall_cnt(sc5)
    );

    int checks = 0;
    int errors = 0;
    int n5, n0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // A branch and a load can never occupy E together.
    always @(negedge clk) begin
        if (rst === 1'b0 && branch_taken_e && load_e) begin
            errors++;
            $error("FAIL isa_excl observed=branch&load expected=exclusive");
        end
    end

    initial begin
        rst = 1'b1;
        rs1_d = '0; rs2_d = '0; rd_e = '0;
        rs1_used_d = 1'b0; rs2_used_d = 1'b0;
        regwrite_e = 1'b0; load_e = 1'b0; branch_taken_e = 1'b0;
        mreq0 = 1'b0; mreq2 = 1'b1; mreq5 = 1'b0;
`ifdef MEM_HS_EN
        mem_ready = 1'b0;
`endif
        settle();
        chk("rst_en2", 32'(en2), 32'(5'b11111));
        chk("rst_fl2", 32'(fl2), 32'(3'b111));
        chk("rst_busy2", 32'(busy2), 32'(1'b0));
        cyc();
        mreq2 = 1'b0;
        cyc();
        rst = 1'b0;
        settle();
        chk("idle_en2", 32'(en2), 32'(5'b11111));
        chk("idle_fl2", 32'(fl2), 32'(3'b000));
        chk("idle_busy2", 32'(busy2), 32'(1'b0));
        chk("idle_sc2", sc2, 32'd0);

        // Load-use hazard and its qualifiers
        load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
        settle();
        chk("lu_en2", 32'(en2), 32'(5'b00011));
        chk("lu_fl2", 32'(fl2), 32'(3'b010));
        cyc();
        rd_e = 5'd0;
        settle();
        chk("lu_x0_en2", 32'(en2), 32'(5'b11111));
        chk("lu_x0_fl2", 32'(fl2), 32'(3'b000));
        chk("lu_sc2", sc2, 32'd1);
        cyc();
        rd_e = 5'd5; rs1_used_d = 1'b0;
        settle();
        chk("lu_unused_en2", 32'(en2), 32'(5'b11111));
        cyc();
        rs1_d = 5'd3; rs2_d = 5'd5; rs2_used_d = 1'b1;
        settle();
        chk("lu_rs2_en0", 32'(en0), 32'(5'b00011));
        cyc();
        regwrite_e = 1'b0;
        settle();
        chk("lu_nowr_en2", 32'(en2), 32'(5'b11111));
        cyc();
        load_e = 1'b0; rs2_used_d = 1'b0; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        settle();
        chk("lu_sc0", 32'(sc0), 32'd2);
        chk("lu_sc5", sc5, 32'd2);

`ifdef MEM_HS_EN
        // Handshake: four not-ready cycles, then ready
        mreq2 = 1'b1; mem_ready = 1'b0;
        n5 = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("hs_busy2", 32'(busy2), 32'(1'b1));
            cyc();
        end
        mem_ready = 1'b1;
        settle();
        chk("hs_rel_busy2", 32'(busy2), 32'(1'b0));
        chk("hs_rel_en2", 32'(en2), 32'(5'b11111));
        cyc();
        mreq2 = 1'b0;
        cyc();
        mreq2 = 1'b1;
        settle();
        chk("hs_zero_busy2", 32'(busy2), 32'(1'b0));
        chk("hs_zero_en2", 32'(en2), 32'(5'b11111));
        cyc();
        mreq2 = 1'b0;
        settle();
        chk("hs_sc2", sc2, 32'd6);
`else
        // Fixed latency: MEM_LAT=2 back-to-back, MEM_LAT=0 none, MEM_LAT=5 single pulse
        mreq2 = 1'b1; mreq0 = 1'b1; mreq5 = 1'b1;
        settle();
        chk("m1_busy2", 32'(busy2), 32'(1'b1));
        chk("m1_fl2", 32'(fl2), 32'(3'b001));
        chk("m1_en2", 32'(en2), 32'(5'b00000));
        chk("m1_busy0", 32'(busy0), 32'(1'b0));
        chk("m1_en0", 32'(en0), 32'(5'b11111));
        chk("m1_busy5", 32'(busy5), 32'(1'b1));
        cyc();
        mreq5 = 1'b0;
        settle();
        chk("m2_busy2", 32'(busy2), 32'(1'b1));
        chk("m2_en2", 32'(en2), 32'(5'b00000));
        cyc();
        settle();
        chk("m3_busy2", 32'(busy2), 32'(1'b0));
        chk("m3_fl2", 32'(fl2), 32'(3'b000));
        chk("m3_en2", 32'(en2), 32'(5'b11111));
        chk("m3_busy5", 32'(busy5), 32'(1'b1));
        cyc();
        settle();
        chk("m4_busy2", 32'(busy2), 32'(1'b1));
        cyc();
        settle();
        chk("m5_busy2", 32'(busy2), 32'(1'b1));
        chk("m5_busy5", 32'(busy5), 32'(1'b1));
        cyc();
        mreq2 = 1'b0; mreq0 = 1'b0;
        settle();
        chk("m6_busy2", 32'(busy2), 32'(1'b0));
        chk("m6_busy5", 32'(busy5), 32'(1'b0));
        cyc();
        chk("m_sc2", sc2, 32'd6);
        chk("m_sc0", 32'(sc0), 32'd2);
        chk("m_sc5", sc5, 32'd7);

        for (int a = 0; a < 2; a++) begin
            n5 = 0; n0 = 0;
            mreq5 = 1'b1; mreq0 = 1'b1;
            for (int i = 0; i < 8; i++) begin
                settle();
                if (busy5) n5++;
                if (busy0) n0++;
                cyc();
                mreq5 = 1'b0; mreq0 = 1'b0;
            end
            chk("lat5_cycles", 32'(n5), 32'd5);
            chk("lat0_cycles", 32'(n0), 32'd0);
        end
        chk("lat5_sc5", sc5, 32'd17);
        chk("lat0_sc0", 32'(sc0), 32'd2);

        // Branch held off by a memory stall, applied on release
        branch_taken_e = 1'b1; mreq2 = 1'b1;
        settle();
        chk("br1_fl2", 32'(fl2), 32'(3'b001));
        chk("br1_en2", 32'(en2), 32'(5'b00000));
        chk("br1_fl0", 32'(fl0), 32'(3'b110));
        cyc();
        settle();
        chk("br2_fl2", 32'(fl2), 32'(3'b001));
        cyc();
        settle();
        chk("br3_fl2", 32'(fl2), 32'(3'b110));
        chk("br3_en2", 32'(en2), 32'(5'b11111));
        cyc();
        branch_taken_e = 1'b0; mreq2 = 1'b0;

        // Load-use held off by a memory stall, bubble on release
        mreq2 = 1'b1; load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9; rs1_used_d = 1'b1;
        settle();
        chk("lw1_fl2", 32'(fl2), 32'(3'b001));
        chk("lw1_en2", 32'(en2), 32'(5'b00000));
        cyc();
        settle();
        chk("lw2_busy2", 32'(busy2), 32'(1'b1));
        cyc();
        settle();
        chk("lw3_fl2", 32'(fl2), 32'(3'b010));
        chk("lw3_en2", 32'(en2), 32'(5'b00011));
        cyc();
        mreq2 = 1'b0; load_e = 1'b0; regwrite_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd0; rs1_used_d = 1'b0;
        settle();
        chk("lw_sc2", sc2, 32'd11);
        chk("lw_sc0", 32'(sc0), 32'd5);
        chk("lw_sc5", sc5, 32'd20);
`endif

        // Reset while the MEM_LAT=5 instance is mid-wait
        mreq5 = 1'b1;
`ifdef MEM_HS_EN
        mem_ready = 1'b0;
`endif
        settle();
        chk("rw1_busy5", 32'(busy5), 32'(1'b1));
        cyc();
        settle();
        chk("rw2_busy5", 32'(busy5), 32'(1'b1));
        rst = 1'b1; mreq5 = 1'b0;
`ifdef MEM_HS_EN
        mem_ready = 1'b1;
`endif
        settle();
        chk("rw_rst_en5", 32'(en5), 32'(5'b11111));
        chk("rw_rst_fl5", 32'(fl5), 32'(3'b111));
        chk("rw_rst_busy5", 32'(busy5), 32'(1'b0));
        cyc();
        rst = 1'b0;
        settle();
        chk("rw_post_busy5", 32'(busy5), 32'(1'b0));
        chk("rw_post_sc5", sc5, 32'd0);
        chk("rw_post_sc2", sc2, 32'd0);
        cyc();
        settle();
        chk("rw_post2_busy5", 32'(busy5), 32'(1'b0));
        chk("rw_post2_sc5", sc5, 32'd0);

        // Stall counter saturation on the 3-bit instance
        load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used_d = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
        end
        load_e = 1'b0; regwrite_e = 1'b0; rs2_used_d = 1'b0;
        settle();
        chk("sat_sc0", 32'(sc0), 32'd7);
        chk("sat_sc2", sc2, 32'd9);
        cyc();
        chk("sat_hold_sc0", 32'(sc0), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline enable/flush controller for the five-stage RV32 core: PC, F/D, D/E, E/M, M/W. It detects load-use hazards with source-usage and x0 qualification, and stalls the whole pipeline for data-memory accesses using a configurable-latency wait FSM. It issues branch and bubble flushes and keeps a saturating stall-cycle counter. It sits beside the datapath and drives every pipeline-register enable and flush.

## Interface
- REG_AW, 5: register-address width.
- MEM_LAT, 2: stall cycles per M-stage memory access in fixed-latency mode; legal range 0..15.
- CNT_W, 32: stall counter width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rs1_d, rs2_d  in  REG_AW  D-stage source registers.
- rs1_used_d, rs2_used_d  in  1  D-stage instruction actually reads rs1/rs2.
- rd_e  in  REG_AW  E-stage destination.
- regwrite_e  in  1  E-stage writes rd.
- load_e  in  1  E-stage is a load (result from memory).
- branch_taken_e  in  1  E-stage redirect (branch taken / jump).
- mem_req_m  in  1  M-stage read or write.
- mem_ready  in  1  memory completion; present only with MEM_HS_EN.
- en_pc, en_f, en_d, en_e, en_m  out  1  register enables.
- flush_d, flush_e, flush_w  out  1  insert bubble into F/D, D/E, M/W.
- mem_busy  out  1  memory wait in progress (= mem_wait).
- stall_cnt  out  CNT_W  cycles with en_pc=0, saturating.

## Operation
- lwstall = load_e & regwrite_e & (rd_e != 0) & ((rs1_used_d & rs1_d==rd_e) | (rs2_used_d & rs2_d==rd_e)).
- Memory FSM, fixed-latency mode, states IDLE/WAIT/DONE, counter cnt of width $clog2(MEM_LAT+1).
  - IDLE: mem_req_m & MEM_LAT>0 → cnt<=1; next state is WAIT if MEM_LAT>1, else DONE.
  - WAIT: cnt++; when cnt==MEM_LAT-1 → DONE.
  - DONE: → IDLE unconditionally; mem_req_m is ignored so the same access cannot retrigger.
- mem_wait = (IDLE & mem_req_m & MEM_LAT>0) | WAIT. This gives exactly MEM_LAT stall cycles, then one release cycle.
- Enables and flushes:
  - ready_w = ~mem_wait.
  - en_e = en_m = ready_w.
  - en_pc = en_f = en_d = ready_w & ~lwstall.
  - flush_d = branch_taken_e & ready_w.
  - flush_e = (branch_taken_e | lwstall) & ready_w.
  - flush_w = mem_wait (prevents duplicate writeback).
- branch_taken_e and load_e are mutually exclusive by ISA, since the E-stage instruction is one or the other. The bench must flag the case where both are set.
- Branch during mem_wait: no flush, all stages held. The redirect reapplies on the release cycle.
- lwstall during mem_wait: mem_wait dominates and no flush_e is issued. The load-use bubble is inserted on the release cycle.
- stall_cnt increments when en_pc==0 and holds at all-ones.
- Reset:
  - state is IDLE, cnt and stall_cnt are 0.
  - While rst is high: all en_* = 1, all flush_* = 1, mem_busy = 0.
  - Reset during WAIT abandons the access, with no further stall.

## Timing
- All enables and flushes are combinational from inputs plus FSM state, in the same cycle.
- Registered elements are state, cnt and stall_cnt only.
- MEM_LAT=0: no memory stall at all; en_* depend only on lwstall.
- Back-to-back accesses (next instruction in M right after DONE→IDLE) each take MEM_LAT stall cycles; there is no overlap.
- stall_cnt updates one cycle after the stalled cycle.

## Configuration
- MEM_HS_EN defined:
  - mem_ready port exists and MEM_LAT is ignored.
  - mem_wait = mem_req_m & ~mem_ready in IDLE and WAIT.
  - IDLE → WAIT on mem_req_m & ~mem_ready; WAIT → IDLE on mem_ready. DONE is unused.
  - mem_ready high in the request cycle means zero stall.
- MEM_HS_EN undefined: fixed-latency FSM as above, with no mem_ready port.

## Structure
- Package pipe_hazard_pkg holds:
  - the FSM state typedef (IDLE, WAIT, DONE);
  - the MEM_LAT maximum constant;
  - the enable-vector index constants.
- Sub-module mem_wait_fsm holds the state, cnt and handshake logic, and outputs mem_wait.
- The top holds hazard compare, enable/flush equations and stall_cnt.

## Test plan
- Load-use: load_e=1, regwrite_e=1, rd_e=5, rs1_d=5, rs1_used_d=1 → en_pc=en_f=en_d=0, flush_e=1, en_e=1 for one cycle. Same with rd_e=0, or with rs1_used_d=0 → no stall.
- Fixed latency MEM_LAT=2: mem_req_m held 3 cycles → mem_busy=1,1,0, flush_w=1,1,0, en_m=0,0,1. The next request starts 2 more stall cycles.
- MEM_LAT=0 and MEM_LAT=5: stall counts of 0 and 5 per access; stall_cnt after 3 MEM_LAT=5 accesses is 15.
- Branch during memory stall: branch_taken_e=1 with mem_busy=1 → flush_d=flush_e=0 until release, then flush_d=flush_e=1 on the release cycle.
- MEM_HS_EN: mem_ready low for 4 cycles, then high → 4 stall cycles. mem_ready=1 in the request cycle → 0 stall.
- Reset in WAIT: assert rst mid-stall → all flush_*=1 and all en_*=1 during reset; after reset mem_busy=0 and stall_cnt=0.
